// File: rtl/alu_adder_hold.sv
// alu_adder_hold
// --------------
// Multi-cycle ALU with an adder hold register. A one-cycle start request
// captures the operands, the operation is computed in CALC, and a decimal SUM
// takes one extra DADJ cycle for BCD adjustment. The result and flags are
// registered and hold their values until the next operation or a reset.
//
// Ports:
//   clk            single clock, rising-edge active
//   rst_N          asynchronous active-low reset
//   a_REG_IN[7:0]  A operand
//   b_REG_IN[7:0]  B operand
//   carry_IN       carry into SUM, bit shifted into bit 7 for SR
//   decimal_EN     BCD adjust for SUM
//   op_SEL[2:0]    0=SUM 1=AND 2=EOR 3=OR 4=SR, 5-7 reserved (result 0)
//   start_EN       one-cycle request to begin an operation
//   add_REG_OUT    adder hold register
//   carry_OUT, overflow_OUT, halfCarry_OUT   registered flags
//   busy_OUT       high while an operation is in flight
//   done_OUT       one-cycle pulse when result and flags are final

module alu_adder_hold (
    input  logic       clk,
    input  logic       rst_N,
    input  logic [7:0] a_REG_IN,
    input  logic [7:0] b_REG_IN,
    input  logic       carry_IN,
    input  logic       decimal_EN,
    input  logic [2:0] op_SEL,
    input  logic       start_EN,
    output logic [7:0] add_REG_OUT,
    output logic       carry_OUT,
    output logic       overflow_OUT,
    output logic       halfCarry_OUT,
    output logic       busy_OUT,
    output logic       done_OUT
);

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SR  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DADJ = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] a_op;
    logic [7:0] b_op;
    logic       cin_op;
    logic       dec_op;
    logic [2:0] sel_op;

    logic       capture;
    logic [7:0] result_next;
    logic       carry_next;
    logic       overflow_next;
    logic       half_next;
    logic       done_next;

    logic [8:0] sum_wide;
    logic [4:0] low_nibble_sum;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_half;

    logic       low_fix;
    logic [8:0] step1_wide;
    logic       high_fix;
    logic [7:0] adj_result;
    logic       adj_carry;

    // Busy is simply "not idle"; it drops in the same cycle the registered
    // done pulse appears because both follow the transition back to IDLE.
    assign busy_OUT = (state != IDLE);

    // ALU datapath working only on the captured operands, so input changes
    // after the start edge cannot disturb an operation in flight.
    always_comb begin
        sum_wide       = {1'b0, a_op} + {1'b0, b_op} + {8'b0, cin_op};
        low_nibble_sum = {1'b0, a_op[3:0]} + {1'b0, b_op[3:0]} + {4'b0, cin_op};
        alu_result     = 8'h00;
        alu_carry      = 1'b0;
        alu_overflow   = 1'b0;
        alu_half       = 1'b0;
        case (sel_op)
            OP_SUM: begin
                alu_result   = sum_wide[7:0];
                alu_carry    = sum_wide[8];
                alu_half     = low_nibble_sum[4];
                alu_overflow = (a_op[7] == b_op[7]) && (a_op[7] != sum_wide[7]);
            end
            OP_AND: alu_result = a_op & b_op;
            OP_EOR: alu_result = a_op ^ b_op;
            OP_OR:  alu_result = a_op | b_op;
            OP_SR: begin
                alu_result = {cin_op, a_op[7:1]};
                alu_carry  = a_op[0];
            end
            default: begin
                alu_result = 8'h00;
            end
        endcase
    end

    // Decimal adjust of the binary sum held in the output register. Operands
    // that are not valid BCD go through the same two steps with no special
    // casing; the carry out of the low-digit fix feeds the high-digit test.
    always_comb begin
        low_fix    = (add_REG_OUT[3:0] > 4'd9) || halfCarry_OUT;
        step1_wide = {1'b0, add_REG_OUT} + (low_fix ? 9'h006 : 9'h000);
        high_fix   = (step1_wide[7:4] > 4'd9) || carry_OUT || step1_wide[8];
        adj_result = step1_wide[7:0] + (high_fix ? 8'h60 : 8'h00);
        adj_carry  = high_fix ? 1'b1 : carry_OUT;
    end

    // Next-state and next-output logic. Everything defaults to holding, so
    // IDLE without a start leaves the outputs untouched and start requests
    // outside IDLE fall through unnoticed.
    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        result_next   = add_REG_OUT;
        carry_next    = carry_OUT;
        overflow_next = overflow_OUT;
        half_next     = halfCarry_OUT;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (start_EN) begin
                    capture    = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                result_next   = alu_result;
                carry_next    = alu_carry;
                overflow_next = alu_overflow;
                half_next     = alu_half;
                if ((sel_op == OP_SUM) && dec_op) begin
                    state_next = DADJ;
                end else begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            DADJ: begin
                result_next = adj_result;
                carry_next  = adj_carry;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture registers, loaded only on an accepted start.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            a_op   <= 8'h00;
            b_op   <= 8'h00;
            cin_op <= 1'b0;
            dec_op <= 1'b0;
            sel_op <= 3'd0;
        end else if (capture) begin
            a_op   <= a_REG_IN;
            b_op   <= b_REG_IN;
            cin_op <= carry_IN;
            dec_op <= decimal_EN;
            sel_op <= op_SEL;
        end
    end

    // Result, flag and done registers. A reset mid-operation clears done
    // along with everything else, so an aborted operation never signals.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            add_REG_OUT   <= 8'h00;
            carry_OUT     <= 1'b0;
            overflow_OUT  <= 1'b0;
            halfCarry_OUT <= 1'b0;
            done_OUT      <= 1'b0;
        end else begin
            add_REG_OUT   <= result_next;
            carry_OUT     <= carry_next;
            overflow_OUT  <= overflow_next;
            halfCarry_OUT <= half_next;
            done_OUT      <= done_next;
        end
    end

endmodule

// File: tb/tb_alu_adder_hold.sv
// tb_alu_adder_hold
// -----------------
// Scoreboard bench for alu_adder_hold. Each accepted request pushes its
// hand-computed result, flags and the cycle in which done must appear; a
// monitor pops one entry per done pulse and compares.

module tb_alu_adder_hold;

    logic       clk = 1'b0;
    logic       rst_N = 1'b1;
    logic [7:0] a_REG_IN = 8'h00;
    logic [7:0] b_REG_IN = 8'h00;
    logic       carry_IN = 1'b0;
    logic       decimal_EN = 1'b0;
    logic [2:0] op_SEL = 3'd0;
    logic       start_EN = 1'b0;
    logic [7:0] add_REG_OUT;
    logic       carry_OUT;
    logic       overflow_OUT;
    logic       halfCarry_OUT;
    logic       busy_OUT;
    logic       done_OUT;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       h;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    alu_adder_hold dut (
        .clk          (clk),
        .rst_N        (rst_N),
        .a_REG_IN     (a_REG_IN),
        .b_REG_IN     (b_REG_IN),
        .carry_IN     (carry_IN),
        .decimal_EN   (decimal_EN),
        .op_SEL       (op_SEL),
        .start_EN     (start_EN),
        .add_REG_OUT  (add_REG_OUT),
        .carry_OUT    (carry_OUT),
        .overflow_OUT (overflow_OUT),
        .halfCarry_OUT(halfCarry_OUT),
        .busy_OUT     (busy_OUT),
        .done_OUT     (done_OUT)
    );

    // Free-running clock and a cycle counter stepped on every rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one request at the current (post-negedge) point; the start edge
    // is the next rising edge, and done must be visible lat-1 cycles after it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input logic dec, input logic [2:0] op, input logic [7:0] er,
                                 input logic ec, input logic ev, input logic eh, input int lat);
        exp_t e;
        a_REG_IN   = a;
        b_REG_IN   = b;
        carry_IN   = c;
        decimal_EN = dec;
        op_SEL     = op;
        start_EN   = 1'b1;
        e.res = er;
        e.c   = ec;
        e.v   = ev;
        e.h   = eh;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        start_EN = 1'b0;
    endtask

    // Wait until every outstanding expectation has been consumed.
    task automatic waitDone();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_N && done_OUT) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("result",   add_REG_OUT, mon_e.res);
                checkOutput("carry",    carry_OUT, mon_e.c);
                checkOutput("overflow", overflow_OUT, mon_e.v);
                checkOutput("halfcarry", halfCarry_OUT, mon_e.h);
                checkOutput("latency_cycle", cyc, mon_e.cyc);
                checkOutput("busy_at_done", busy_OUT, 0);
            end
        end
    end

    initial begin
        $display("[TB] start");
        #1 rst_N = 1'b0;
        #1;
        checkOutput("reset_result", add_REG_OUT, 8'h00);
        checkOutput("reset_flags", {carry_OUT, overflow_OUT, halfCarry_OUT}, 3'b000);
        checkOutput("reset_busy_done", {busy_OUT, done_OUT}, 2'b00);
        repeat (2) @(negedge clk);
        rst_N = 1'b1;

        // Binary overflow, started on the first edge after reset release.
        applyStimulus(8'h50, 8'h50, 1'b0, 1'b0, 3'd0, 8'hA0, 1'b0, 1'b1, 1'b0, 2);
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("hold_result", add_REG_OUT, 8'hA0);
        checkOutput("hold_overflow", overflow_OUT, 1'b1);
        checkOutput("idle_busy", busy_OUT, 1'b0);

        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 2);
        waitDone();
        applyStimulus(8'h09, 8'h01, 1'b0, 1'b1, 3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 3);
        waitDone();
        applyStimulus(8'h99, 8'h01, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3);
        waitDone();
        applyStimulus(8'h15, 8'h27, 1'b1, 1'b1, 3'd0, 8'h43, 1'b0, 1'b0, 1'b0, 3);
        waitDone();
        applyStimulus(8'h08, 8'h08, 1'b0, 1'b1, 3'd0, 8'h16, 1'b0, 1'b0, 1'b1, 3);
        waitDone();
        applyStimulus(8'h81, 8'h00, 1'b1, 1'b0, 3'd4, 8'hC0, 1'b1, 1'b0, 1'b0, 2);
        waitDone();
        applyStimulus(8'hF0, 8'hFF, 1'b0, 1'b0, 3'd2, 8'h0F, 1'b0, 1'b0, 1'b0, 2);
        waitDone();
        applyStimulus(8'h3C, 8'h0F, 1'b1, 1'b0, 3'd1, 8'h0C, 1'b0, 1'b0, 1'b0, 2);
        waitDone();
        applyStimulus(8'h30, 8'h05, 1'b0, 1'b0, 3'd3, 8'h35, 1'b0, 1'b0, 1'b0, 2);
        waitDone();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 2);
        waitDone();

        // Start pulsed during DADJ must be ignored: one done only.
        applyStimulus(8'h09, 8'h01, 1'b0, 1'b1, 3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        checkOutput("busy_in_dadj", busy_OUT, 1'b1);
        a_REG_IN = 8'h11;
        b_REG_IN = 8'h22;
        decimal_EN = 1'b0;
        start_EN = 1'b1;
        @(negedge clk);
        start_EN = 1'b0;
        waitDone();
        repeat (4) @(negedge clk);
        checkOutput("no_queued_start", busy_OUT, 1'b0);

        // Leave non-zero state, then reset in the middle of CALC.
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0, 1'b0, 1'b1, 2);
        waitDone();
        a_REG_IN = 8'h01;
        b_REG_IN = 8'h01;
        op_SEL = 3'd0;
        decimal_EN = 1'b0;
        start_EN = 1'b1;
        @(negedge clk);
        start_EN = 1'b0;
        checkOutput("busy_in_calc", busy_OUT, 1'b1);
        #2 rst_N = 1'b0;
        #1;
        checkOutput("abort_result", add_REG_OUT, 8'h00);
        checkOutput("abort_flags", {carry_OUT, overflow_OUT, halfCarry_OUT}, 3'b000);
        checkOutput("abort_busy_done", {busy_OUT, done_OUT}, 2'b00);
        repeat (2) @(negedge clk);
        rst_N = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("after_abort_busy", busy_OUT, 1'b0);
        checkOutput("after_abort_result", add_REG_OUT, 8'h00);

        // Back-to-back with start held high; operands scrambled while in CALC.
        start_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            case (i)
                0: begin
                    a_REG_IN = 8'h10; b_REG_IN = 8'h20; carry_IN = 1'b0; decimal_EN = 1'b0; op_SEL = 3'd0;
                    e.res = 8'h30; e.c = 1'b0; e.v = 1'b0; e.h = 1'b0;
                end
                1: begin
                    a_REG_IN = 8'h01; b_REG_IN = 8'h80; carry_IN = 1'b0; decimal_EN = 1'b0; op_SEL = 3'd3;
                    e.res = 8'h81; e.c = 1'b0; e.v = 1'b0; e.h = 1'b0;
                end
                default: begin
                    a_REG_IN = 8'h02; b_REG_IN = 8'h00; carry_IN = 1'b0; decimal_EN = 1'b0; op_SEL = 3'd4;
                    e.res = 8'h01; e.c = 1'b0; e.v = 1'b0; e.h = 1'b0;
                end
            endcase
            e.cyc = cyc + 2;
            exp_q.push_back(e);
            @(negedge clk);
            a_REG_IN = 8'hFF;
            b_REG_IN = 8'hFF;
            carry_IN = 1'b1;
            decimal_EN = 1'b1;
            op_SEL = 3'd0;
            @(negedge clk);
        end
        start_EN = 1'b0;
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
